// File: rtl/adder_nibble_arb_if.sv
// Bus between adder_nibble_arb, its two requesters and the shared external 4-bit adder.
// The ovf signal exists only when ADDER_NIBBLE_ARB_OVF_EN is defined.
interface adder_nibble_arb_if #(
  parameter int WIDTH = 16
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin0;
  logic             cin1;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;
  logic             busy;
  logic             gnt_id;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             done0;
  logic             done1;
`ifdef ADDER_NIBBLE_ARB_OVF_EN
  logic             ovf;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    output add_a, add_b, add_cin, busy, gnt_id, sum, cout, done0, done1, ovf
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    input  add_a, add_b, add_cin, busy, gnt_id, sum, cout, done0, done1, ovf
  );
`else
  modport slave (
    input  req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    output add_a, add_b, add_cin, busy, gnt_id, sum, cout, done0, done1
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, cin0, cin1, add_sum, add_cout,
    input  add_a, add_b, add_cin, busy, gnt_id, sum, cout, done0, done1
  );
`endif
endinterface

// File: rtl/adder_nibble_arb.sv
// Two-requester round-robin arbiter that performs WIDTH-bit additions one nibble per cycle
// on a shared external 4-bit adder. Define ADDER_NIBBLE_ARB_OVF_EN to add the ovf output.
module adder_nibble_arb #(
  parameter  int WIDTH = 16,
  localparam int NIBS  = WIDTH / 4
) (
  input logic              clk,
  input logic              rst,
  adder_nibble_arb_if.slave bus
);

  localparam int IDXW = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic             w_start;
  logic             w_sel;
  logic             w_lastNib;
  logic [3:0]       w_nibA;
  logic [3:0]       w_nibB;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_sum;
  logic             r_cin;
  logic             r_carry;
  logic             r_cout;
  logic             r_gntId;
  logic             r_rrPtr;
  logic [IDXW-1:0]  r_idx;

  assign w_lastNib = (r_idx == IDXW'(NIBS - 1));
  assign w_nibA    = r_opA[4*r_idx +: 4];
  assign w_nibB    = r_opB[4*r_idx +: 4];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // r_rrPtr names the requester that wins a tie; only IDLE can start an operation
  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_sel       = r_rrPtr;
    case (r_state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_start     = 1'b1;
          w_nextState = RUN;
          w_sel       = (bus.req0 && bus.req1) ? r_rrPtr : bus.req1;
        end
      end
      RUN: begin
        if (w_lastNib) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opA   <= '0;
      r_opB   <= '0;
      r_cin   <= 1'b0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_gntId <= 1'b0;
      r_rrPtr <= 1'b0;
      r_idx   <= '0;
    end else begin
      // Operands are captured once at grant so later input changes cannot leak in
      if (w_start) begin
        r_gntId <= w_sel;
        r_rrPtr <= ~w_sel;
        r_idx   <= '0;
        r_opA   <= w_sel ? bus.a1 : bus.a0;
        r_opB   <= w_sel ? bus.b1 : bus.b0;
        r_cin   <= w_sel ? bus.cin1 : bus.cin0;
      end
      if (r_state == RUN) begin
        r_sum[4*r_idx +: 4] <= bus.add_sum;
        r_carry             <= bus.add_cout;
        r_idx               <= r_idx + 1'b1;
        if (w_lastNib) begin
          r_cout <= bus.add_cout;
        end
      end
    end
  end

`ifdef ADDER_NIBBLE_ARB_OVF_EN
  logic r_ovf;
  logic w_msbCarryIn;

  // Carry into the MSB is recovered from the operand MSBs and the adder's top sum bit
  assign w_msbCarryIn = r_opA[WIDTH-1] ^ r_opB[WIDTH-1] ^ bus.add_sum[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == RUN) && w_lastNib) begin
      r_ovf <= w_msbCarryIn ^ bus.add_cout;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.add_a   = (r_state == RUN) ? w_nibA : 4'h0;
  assign bus.add_b   = (r_state == RUN) ? w_nibB : 4'h0;
  assign bus.add_cin = (r_state == RUN) ? ((r_idx == '0) ? r_cin : r_carry) : 1'b0;
  assign bus.busy    = (r_state != IDLE);
  assign bus.gnt_id  = r_gntId;
  assign bus.sum     = r_sum;
  assign bus.cout    = r_cout;
  assign bus.done0   = (r_state == DONE) && !r_gntId;
  assign bus.done1   = (r_state == DONE) && r_gntId;

endmodule

// File: tb/tb_adder_nibble_arb.sv
// Scoreboard bench for adder_nibble_arb; models the external 4-bit adder combinationally.
// Define ADDER_NIBBLE_ARB_OVF_EN to also exercise the ovf output.
module tb_adder_nibble_arb;

  localparam int WIDTH = 16;
  localparam int NIBS  = WIDTH / 4;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  adder_nibble_arb_if #(.WIDTH(WIDTH)) bus ();

  adder_nibble_arb #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'b0000, bus.add_cin};

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
    exp_t             e;
    logic [WIDTH:0]   full;
    full   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    e.id   = id;
    e.sum  = full[WIDTH-1:0];
    e.cout = full[WIDTH];
    e.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return e;
  endfunction

  // Drives one requester and records what its operation must produce
  task automatic applyStimulus(input logic id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin);
    if (id) begin
      bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1'b1;
    end else begin
      bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1'b1;
    end
    sbQ.push_back(model(id, a, b, cin));
  endtask

  task automatic waitDone(output bit got, output bit d0, output bit d1, output int cycles);
    got = 1'b0; d0 = 1'b0; d1 = 1'b0; cycles = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      cycles++;
      if (bus.done0 || bus.done1) begin
        got = 1'b1; d0 = bus.done0; d1 = bus.done1;
      end
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
  endtask

  task automatic popExpected(output exp_t e);
    if (sbQ.size() == 0) begin
      e = '{id: 1'bx, sum: 'x, cout: 1'bx, ovf: 1'bx};
    end else begin
      e = sbQ.pop_front();
    end
  endtask

  task automatic test_reset();
    doReset();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.gnt_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_gnt got %b want 0", bus.gnt_id); end
    checks++; if ({bus.done0, bus.done1} !== 2'b00) begin errors++; $display("[TB] FAIL reset_done got %b%b want 00", bus.done0, bus.done1); end
    checks++; if (bus.sum !== '0) begin errors++; $display("[TB] FAIL reset_sum got %h want 0", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL reset_cout got %b want 0", bus.cout); end
    checks++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h0) begin errors++; $display("[TB] FAIL reset_adder got %h/%h/%b want 0", bus.add_a, bus.add_b, bus.add_cin); end
  endtask

  task automatic test_basic();
    exp_t e; bit got, d0, d1; int cyc;
    @(negedge clk);
    applyStimulus(1'b0, 16'h1234, 16'h0FCD, 1'b0);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy got %b want 1", bus.busy); end
    checks++; if (bus.gnt_id !== 1'b0) begin errors++; $display("[TB] FAIL basic_gnt got %b want 0", bus.gnt_id); end
    waitDone(got, d0, d1, cyc);
    bus.req0 = 1'b0;
    popExpected(e);
    checks++; if (!got || cyc != NIBS) begin errors++; $display("[TB] FAIL basic_latency got %0d want %0d", got ? cyc : -1, NIBS); end
    checks++; if ({d0, d1} !== 2'b10) begin errors++; $display("[TB] FAIL basic_done got %b%b want 10", d0, d1); end
    checks++; if (bus.sum !== e.sum || bus.sum !== 16'h2201) begin errors++; $display("[TB] FAIL basic_sum got %h want %h", bus.sum, e.sum); end
    checks++; if (bus.cout !== e.cout) begin errors++; $display("[TB] FAIL basic_cout got %b want %b", bus.cout, e.cout); end
    @(negedge clk);
    checks++; if ({bus.done0, bus.busy} !== 2'b00) begin errors++; $display("[TB] FAIL basic_pulse got done0=%b busy=%b want 0 0", bus.done0, bus.busy); end
  endtask

  task automatic test_req1();
    exp_t e; bit got, d0, d1; int cyc;
    @(negedge clk);
    applyStimulus(1'b1, 16'hFFFF, 16'h0000, 1'b1);
    waitDone(got, d0, d1, cyc);
    bus.req1 = 1'b0;
    popExpected(e);
    checks++; if (!got || {d0, d1} !== 2'b01) begin errors++; $display("[TB] FAIL req1_done got %b%b want 01", d0, d1); end
    checks++; if (bus.sum !== e.sum) begin errors++; $display("[TB] FAIL req1_sum got %h want %h", bus.sum, e.sum); end
    checks++; if (bus.cout !== 1'b1) begin errors++; $display("[TB] FAIL req1_cout got %b want 1", bus.cout); end
  endtask

  task automatic test_operand_hold();
    exp_t e; bit got, d0, d1; int cyc;
    @(negedge clk);
    applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    bus.a0 = 16'hFFFF; bus.b0 = 16'hFFFF; bus.cin0 = 1'b1; bus.req0 = 1'b0;
    waitDone(got, d0, d1, cyc);
    popExpected(e);
    checks++; if (!got || {d0, d1} !== 2'b10) begin errors++; $display("[TB] FAIL hold_done got %b%b want 10", d0, d1); end
    checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin errors++; $display("[TB] FAIL hold_sum got %b_%h want %b_%h", bus.cout, bus.sum, e.cout, e.sum); end
  endtask

  task automatic test_reset_abort();
    exp_t e; bit got, d0, d1, sawDone; int cyc;
    @(negedge clk);
    applyStimulus(1'b0, 16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1; bus.req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    checks++; if ({bus.busy, bus.done0, bus.done1, bus.cout} !== 4'b0000) begin errors++; $display("[TB] FAIL abort_ctrl got %b%b%b%b want 0000", bus.busy, bus.done0, bus.done1, bus.cout); end
    checks++; if (bus.sum !== '0) begin errors++; $display("[TB] FAIL abort_sum got %h want 0", bus.sum); end
    checks++; if ({bus.add_a, bus.add_b, bus.add_cin} !== 9'h0) begin errors++; $display("[TB] FAIL abort_adder got %h/%h/%b want 0", bus.add_a, bus.add_b, bus.add_cin); end
    sawDone = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (bus.done0 || bus.done1) sawDone = 1'b1;
    end
    checks++; if (sawDone !== 1'b0) begin errors++; $display("[TB] FAIL abort_nodone got %b want 0", sawDone); end
    applyStimulus(1'b0, 16'h0FF0, 16'h0010, 1'b0);
    waitDone(got, d0, d1, cyc);
    bus.req0 = 1'b0;
    popExpected(e);
    checks++; if (!got || cyc != NIBS + 1 || {d0, d1} !== 2'b10) begin errors++; $display("[TB] FAIL abort_redo got cyc=%0d done=%b%b want cyc=%0d done=10", cyc, d0, d1, NIBS + 1); end
    checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin errors++; $display("[TB] FAIL abort_redo_sum got %b_%h want %b_%h", bus.cout, bus.sum, e.cout, e.sum); end
  endtask

  task automatic test_back_to_back();
    exp_t e; bit got, d0, d1; int cyc;
    doReset();
    @(negedge clk);
    applyStimulus(1'b0, WIDTH'($urandom), WIDTH'($urandom), 1'b0);
    applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1);
    for (int op = 0; op < 4; op++) begin
      waitDone(got, d0, d1, cyc);
      popExpected(e);
      checks++; if (!got || (d0 && d1)) begin errors++; $display("[TB] FAIL b2b_done%0d got %b%b want one pulse", op, d0, d1); end
      checks++; if (d1 !== e.id || d0 !== !e.id) begin errors++; $display("[TB] FAIL b2b_order%0d got %b%b want id %b", op, d0, d1, e.id); end
      checks++; if (cyc != ((op == 0) ? NIBS + 1 : NIBS + 2)) begin errors++; $display("[TB] FAIL b2b_gap%0d got %0d want %0d", op, cyc, (op == 0) ? NIBS + 1 : NIBS + 2); end
      checks++; if (bus.sum !== e.sum || bus.cout !== e.cout) begin errors++; $display("[TB] FAIL b2b_sum%0d got %b_%h want %b_%h", op, bus.cout, bus.sum, e.cout, e.sum); end
      if (op < 2) applyStimulus(e.id, WIDTH'($urandom), WIDTH'($urandom), op[0]);
      else if (op == 2) bus.req0 = 1'b0;
      else bus.req1 = 1'b0;
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle got %b want 0", bus.busy); end
  endtask

`ifdef ADDER_NIBBLE_ARB_OVF_EN
  task automatic test_ovf();
    exp_t e; bit got, d0, d1; int cyc;
    @(negedge clk);
    applyStimulus(1'b0, 16'h7FFF, 16'h0001, 1'b0);
    waitDone(got, d0, d1, cyc);
    bus.req0 = 1'b0;
    popExpected(e);
    checks++; if (!got || bus.sum !== 16'h8000 || bus.cout !== 1'b0) begin errors++; $display("[TB] FAIL ovf_sum got %b_%h want 0_8000", bus.cout, bus.sum); end
    checks++; if (bus.ovf !== e.ovf || bus.ovf !== 1'b1) begin errors++; $display("[TB] FAIL ovf_flag got %b want %b", bus.ovf, e.ovf); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.cin0 = 1'b0; bus.cin1 = 1'b0;
    test_reset();
    test_basic();
    test_req1();
    test_operand_hold();
    test_reset_abort();
    test_back_to_back();
`ifdef ADDER_NIBBLE_ARB_OVF_EN
    test_ovf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/adder_nibble_arb.md
ADDER_NIBBLE_ARB -- requirements
Module: adder_nibble_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 8.
REQ-002 The block SHALL have parameter NIBS, derived as WIDTH/4, giving the number of 4-bit slices per operation.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req0, req1  in  1 each  requester 0/1 asks for one addition; held high until its done pulse.
REQ-006 a0, b0, a1, b1  in  WIDTH each  requester operands; sampled only on that requester's grant edge.
REQ-007 cin0, cin1  in  1 each  requester carry-in; sampled with the operands.
REQ-008 add_a, add_b  out  4 each  nibble operands driven to the shared external 4-bit adder.
REQ-009 add_cin  out  1  carry-in driven to the shared adder.
REQ-010 add_sum  in  4, add_cout  in  1  adder results, valid combinationally within the same cycle.
REQ-011 busy  out  1  high while an operation is in progress (RUN or DONE state).
REQ-012 gnt_id  out  1  id of the requester being served; valid while busy.
REQ-013 sum  out  WIDTH, cout  out  1  result registers; hold the last result until the next done.
REQ-014 done0, done1  out  1 each  single-cycle completion pulse to the served requester.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 IDLE: if any req is high at a clock edge, the block SHALL latch that requester's a, b and cin, set gnt_id, clear the nibble index to 0, and go to RUN.
REQ-017 When both reqs are high in IDLE, the block SHALL grant the requester not served last (round-robin); after reset, requester 0 SHALL win the first tie.
REQ-018 RUN: add_a/add_b SHALL carry latched operand bits [4i+3:4i] for nibble index i; add_cin SHALL be the latched cin for i=0 and the carry register otherwise.
REQ-019 At each RUN edge, add_sum SHALL be written to sum[4i+3:4i], add_cout to the carry register, and i incremented by 1.
REQ-020 After the edge that processes i=NIBS-1, the block SHALL load cout from add_cout and go to DONE.
REQ-021 DONE SHALL last exactly one cycle, with done<gnt_id> high and the other done low; the block SHALL then return to IDLE.
REQ-022 Latency: a req first sampled at edge k SHALL produce a done pulse during the cycle after edge k+NIBS; the next grant SHALL be possible at edge k+NIBS+2.
REQ-023 A req still high in the IDLE cycle after its done SHALL be treated as a new request.
REQ-024 Requests arriving while busy SHALL be ignored until IDLE; operand changes while busy SHALL NOT affect the result.
REQ-025 Dropping the served req mid-operation SHALL NOT abort the operation; its done SHALL still pulse.
REQ-026 Outside RUN, add_a, add_b and add_cin SHALL be driven to 0.
REQ-027 Arithmetic SHALL be unsigned modulo 2^WIDTH, with cout as bit WIDTH of a+b+cin.

Reset
REQ-028 On rst, the block SHALL enter IDLE and clear busy, gnt_id, done0, done1, sum, cout, the carry register, the nibble index and the round-robin pointer (0 = requester 0 preferred).
REQ-029 rst asserted mid-operation SHALL abort the operation with no done pulse; rst SHALL take priority over every other event.

Configuration
REQ-030 With macro ADDER_NIBBLE_ARB_OVF_EN defined, the block SHALL add output ovf (1 bit), reset 0, loaded alongside cout with the two's-complement overflow (carry into the MSB XOR carry out of the MSB).
REQ-031 With ADDER_NIBBLE_ARB_OVF_EN undefined, the ovf port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-032 WIDTH=16: req0 with a0=0x1234, b0=0x0FCD, cin0=0 -> done0 high 5 cycles after the grant edge (4 RUN cycles, then DONE), sum=0x2201, cout=0.
REQ-033 WIDTH=16: req1 with a1=0xFFFF, b1=0x0000, cin1=1 -> sum=0x0000, cout=1, done1 pulses, done0 stays 0.
REQ-034 req0 and req1 held high together from reset -> grants in order 0,1,0,1, one done pulse per operation, no cycle with both dones high.
REQ-035 rst pulsed during the 2nd RUN cycle -> no done pulse; all outputs 0; a new req0 then completes normally.
REQ-036 With ADDER_NIBBLE_ARB_OVF_EN defined: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-037 Change a0 to 0xFFFF after the grant edge of a0=0x0001, b0=0x0001 -> sum=0x0002.
